// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the arbiter slice: addresses, blocks, tags,
// commands, icache request packet and owner-table entry.
package mem_arbiter_pkg;

    localparam int NUM_MEM_TAGS = 15;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic valid;
        ADDR  addr;
    } I_ADDR_PACKET;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_owner_table.sv
// Records which cache owns each outstanding memory tag; tag 0 has no storage.
// A set and a clear of the same tag in one cycle keeps the new owner.
module mem_owner_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           set_en,
    input  MEM_TAG         set_tag,
    input  MEM_OWNER       set_owner,
    input  MEM_TAG         clr_tag,
    output MEM_OWNER_ENTRY lookup
);

    MEM_OWNER_ENTRY r_tab [1:NUM_TAGS];

    always_ff @(posedge clock) begin
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (reset) begin
                r_tab[i] <= '{valid: 1'b0, owner: OWNER_ICACHE};
            end else if (set_en && (set_tag == MEM_TAG'(i))) begin
                r_tab[i] <= '{valid: 1'b1, owner: set_owner};
            end else if (clr_tag == MEM_TAG'(i)) begin
                r_tab[i].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        lookup = '{valid: 1'b0, owner: OWNER_ICACHE};
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (clr_tag == MEM_TAG'(i)) lookup = r_tab[i];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: dcache priority with an icache starvation guard,
// plus tag-to-owner routing of returning data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  I_ADDR_PACKET icache_req,
    output logic         icache_req_accepted,
    input  logic         dcache_req_valid,
    input  MEM_COMMAND   dcache_req_cmd,
    input  ADDR          dcache_req_addr,
    input  MEM_BLOCK     dcache_req_data,
    output logic         dcache_req_accepted,
    output MEM_COMMAND   mem_command,
    output ADDR          mem_addr,
    output MEM_BLOCK     mem_wdata,
    input  MEM_TAG       mem_req_tag,
    input  MEM_TAG       mem_data_tag,
    output MEM_TAG       icache_current_tag,
    output MEM_TAG       dcache_current_tag,
    output MEM_TAG       icache_data_tag,
    output MEM_TAG       dcache_data_tag
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_accept;
    MEM_OWNER_ENTRY   w_entry;

    // Outputs are held quiet while reset is asserted so nothing reaches memory.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (!reset) begin
            if (dcache_req_valid && (r_starve_cnt < LIMIT)) w_grant_d = 1'b1;
            else if (icache_req.valid)                      w_grant_i = 1'b1;
            else if (dcache_req_valid)                      w_grant_d = 1'b1;
        end
    end

    always_comb begin
        mem_command = MEM_NONE;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (w_grant_d) begin
            mem_command = dcache_req_cmd;
            mem_addr    = dcache_req_addr;
            if (dcache_req_cmd == MEM_STORE) mem_wdata = dcache_req_data;
        end else if (w_grant_i) begin
            mem_command = MEM_LOAD;
            mem_addr    = icache_req.addr;
        end
    end

    assign w_accept            = (mem_command != MEM_NONE) && (mem_req_tag != '0);
    assign icache_req_accepted = w_accept && w_grant_i;
    assign dcache_req_accepted = w_accept && w_grant_d;
    assign icache_current_tag  = w_grant_i ? mem_req_tag : '0;
    assign dcache_current_tag  = w_grant_d ? mem_req_tag : '0;

    // A rejected icache grant still counts as a denied cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!icache_req.valid || icache_req_accepted) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt < LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    mem_owner_table #(.NUM_TAGS(NUM_TAGS)) u_owner_table (
        .clock     (clock),
        .reset     (reset),
        .set_en    (w_accept && (mem_command == MEM_LOAD)),
        .set_tag   (mem_req_tag),
        .set_owner (w_grant_d ? OWNER_DCACHE : OWNER_ICACHE),
        .clr_tag   (mem_data_tag),
        .lookup    (w_entry)
    );

    assign icache_data_tag = (!reset && w_entry.valid && (w_entry.owner == OWNER_ICACHE))
                             ? mem_data_tag : '0;
    assign dcache_data_tag = (!reset && w_entry.valid && (w_entry.owner == OWNER_DCACHE))
                             ? mem_data_tag : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a behavioural model of
// the grant, starvation and tag-ownership rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic         clock;
    logic         reset;
    I_ADDR_PACKET icache_req;
    logic         icache_req_accepted;
    logic         dcache_req_valid;
    MEM_COMMAND   dcache_req_cmd;
    ADDR          dcache_req_addr;
    MEM_BLOCK     dcache_req_data;
    logic         dcache_req_accepted;
    MEM_COMMAND   mem_command;
    ADDR          mem_addr;
    MEM_BLOCK     mem_wdata;
    MEM_TAG       mem_req_tag;
    MEM_TAG       mem_data_tag;
    MEM_TAG       icache_current_tag;
    MEM_TAG       dcache_current_tag;
    MEM_TAG       icache_data_tag;
    MEM_TAG       dcache_data_tag;

    int checks = 0;
    int errors = 0;

    // model state: who owns each tag, and how long icache has been refused
    bit own_v [16];
    bit own_d [16];
    int starve;

    // observed values captured at the last step
    logic     cap_iacc, cap_dacc;
    MEM_TAG   cap_icur, cap_dcur, cap_idat, cap_ddat;
    MEM_BLOCK cap_wdata;

    mem_arbiter #(.NUM_TAGS(NUM_MEM_TAGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .icache_req(icache_req), .icache_req_accepted(icache_req_accepted),
        .dcache_req_valid(dcache_req_valid), .dcache_req_cmd(dcache_req_cmd),
        .dcache_req_addr(dcache_req_addr), .dcache_req_data(dcache_req_data),
        .dcache_req_accepted(dcache_req_accepted),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req_tag(mem_req_tag), .mem_data_tag(mem_data_tag),
        .icache_current_tag(icache_current_tag), .dcache_current_tag(dcache_current_tag),
        .icache_data_tag(icache_data_tag), .dcache_data_tag(dcache_data_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit iv, input ADDR ia,
                        input bit dv, input MEM_COMMAND dc, input ADDR da, input MEM_BLOCK dd,
                        input MEM_TAG rt, input MEM_TAG dt);
        bit         win_d, win_i, acc, is_load;
        MEM_COMMAND e_cmd;
        ADDR        e_addr;
        MEM_BLOCK   e_wd;
        MEM_TAG     e_idat, e_ddat;
        reset            = rst;
        icache_req.valid = iv;
        icache_req.addr  = ia;
        dcache_req_valid = dv;
        dcache_req_cmd   = dc;
        dcache_req_addr  = da;
        dcache_req_data  = dd;
        mem_req_tag      = rt;
        mem_data_tag     = dt;
        @(negedge clock);
        win_d = !rst && dv && !(iv && starve >= STARVE_LIMIT);
        win_i = !rst && iv && !win_d;
        e_cmd  = win_d ? dc : (win_i ? MEM_LOAD : MEM_NONE);
        e_addr = win_d ? da : (win_i ? ia : 32'h0);
        e_wd   = (win_d && dc == MEM_STORE) ? dd : 64'h0;
        acc    = (e_cmd != MEM_NONE) && (rt != 0);
        e_idat = 0;
        e_ddat = 0;
        if (!rst && dt != 0 && own_v[int'(dt)]) begin
            if (own_d[int'(dt)]) e_ddat = dt;
            else                 e_idat = dt;
        end
        chk("mem_command", 64'(mem_command), 64'(e_cmd));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", mem_wdata, e_wd);
        chk("icache_acc", 64'(icache_req_accepted), 64'(win_i && acc));
        chk("dcache_acc", 64'(dcache_req_accepted), 64'(win_d && acc));
        chk("icache_cur", 64'(icache_current_tag), 64'(win_i ? rt : MEM_TAG'(0)));
        chk("dcache_cur", 64'(dcache_current_tag), 64'(win_d ? rt : MEM_TAG'(0)));
        chk("icache_dat", 64'(icache_data_tag), 64'(e_idat));
        chk("dcache_dat", 64'(dcache_data_tag), 64'(e_ddat));
        cap_iacc = icache_req_accepted; cap_dacc = dcache_req_accepted;
        cap_icur = icache_current_tag;  cap_dcur = dcache_current_tag;
        cap_idat = icache_data_tag;     cap_ddat = dcache_data_tag;
        cap_wdata = mem_wdata;
        is_load = acc && (e_cmd == MEM_LOAD);
        if (rst) begin
            for (int t = 0; t < 16; t++) own_v[t] = 0;
            starve = 0;
        end else begin
            if (dt != 0) own_v[int'(dt)] = 0;
            if (is_load) begin
                own_v[int'(rt)] = 1;
                own_d[int'(rt)] = win_d;
            end
            if (iv && !(win_i && acc)) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
            else                       starve = 0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        starve = 0;
        for (int t = 0; t < 16; t++) begin own_v[t] = 0; own_d[t] = 0; end
        step(1, 0, 0, 0, MEM_LOAD, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, MEM_STORE, 32'h80, 64'h1, 2, 2);
        // idle: nothing granted, every tag unowned
        for (int t = 1; t < 16; t++) begin
            step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, MEM_TAG'(t));
            chk("empty_idat", 64'(cap_idat), 64'h0);
        end
        // icache load, then its data returns, then the same tag is stale
        step(0, 1, 32'h100, 0, MEM_LOAD, 0, 0, 3, 0);
        chk("ic_acc", 64'(cap_iacc), 64'h1);
        chk("ic_cur", 64'(cap_icur), 64'h3);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 3);
        chk("ic_ret_i", 64'(cap_idat), 64'h3);
        chk("ic_ret_d", 64'(cap_ddat), 64'h0);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 3);
        chk("ic_cleared", 64'(cap_idat), 64'h0);
        // both requesting: dcache x4, icache forced, dcache again
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 32'h300, 1, MEM_LOAD, 32'h400, 0, MEM_TAG'(8 + c), 0);
            chk("starve_i", 64'(cap_iacc), 64'(c == 4));
            chk("starve_d", 64'(cap_dacc), 64'(c != 4));
        end
        // store: wdata driven, no ownership recorded
        step(0, 0, 0, 1, MEM_STORE, 32'h200, 64'hDEAD_BEEF_0123_4567, 5, 0);
        chk("st_acc", 64'(cap_dacc), 64'h1);
        chk("st_wdata", cap_wdata, 64'hDEAD_BEEF_0123_4567);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 5);
        chk("st_ret_i", 64'(cap_idat), 64'h0);
        chk("st_ret_d", 64'(cap_ddat), 64'h0);
        // two rejections leave icache two cycles into its starvation window
        step(0, 1, 32'h500, 0, MEM_LOAD, 0, 0, 0, 0);
        chk("rej_acc", 64'(cap_iacc), 64'h0);
        step(0, 1, 32'h500, 0, MEM_LOAD, 0, 0, 0, 0);
        chk("rej_acc", 64'(cap_iacc), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step(0, 1, 32'h500, 1, MEM_LOAD, 32'h600, 0, 1, 0);
            chk("rej_then_i", 64'(cap_iacc), 64'(c == 2));
        end
        // tag 7 returns to icache while being reissued to dcache
        step(0, 1, 32'h700, 0, MEM_LOAD, 0, 0, 7, 0);
        step(0, 0, 0, 1, MEM_LOAD, 32'h780, 0, 7, 7);
        chk("reuse_i", 64'(cap_idat), 64'h7);
        chk("reuse_d", 64'(cap_ddat), 64'h0);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 7);
        chk("reuse_own", 64'(cap_ddat), 64'h7);
        // reset drops outstanding tags
        step(0, 1, 32'h900, 0, MEM_LOAD, 0, 0, 2, 0);
        step(0, 0, 0, 1, MEM_LOAD, 32'hA00, 0, 4, 0);
        step(1, 0, 0, 0, MEM_LOAD, 0, 0, 0, 0);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 2);
        chk("rst_drop2", 64'({cap_idat, cap_ddat}), 64'h0);
        step(0, 0, 0, 0, MEM_LOAD, 0, 0, 0, 4);
        chk("rst_drop4", 64'({cap_idat, cap_ddat}), 64'h0);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit         r_rst, r_iv, r_dv;
            MEM_COMMAND r_dc;
            MEM_TAG     r_rt, r_dt;
            r_rst = ($urandom_range(0, 59) == 0);
            r_iv  = 1'($urandom_range(0, 1));
            r_dv  = 1'($urandom_range(0, 1));
            r_dc  = ($urandom_range(0, 2) == 0) ? MEM_STORE : MEM_LOAD;
            r_rt  = ($urandom_range(0, 3) == 0) ? MEM_TAG'(0) : MEM_TAG'($urandom_range(1, 15));
            r_dt  = ($urandom_range(0, 1) == 0) ? MEM_TAG'(0) : MEM_TAG'($urandom_range(1, 15));
            step(r_rst, r_iv, $urandom & 32'hFFFF_FFC0, r_dv, r_dc, $urandom & 32'hFFFF_FFC0,
                 {$urandom, $urandom}, r_rt, r_dt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-cache subsystem (miss and prefetch reads) and the data cache (loads and stores). It picks one requester per cycle and drives the memory command. It also tracks which requester owns each outstanding memory tag, so returning data tags reach the correct cache. Dcache has priority, and a starvation counter guarantees icache forward progress.

## Interface
Parameters:
- NUM_TAGS, default `NUM_MEM_TAGS: number of nonzero memory tags; tag 0 means "no transaction".
- STARVE_LIMIT, default 4: consecutive denied icache cycles before icache is forced to win.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- icache_req  in  I_ADDR_PACKET  icache read request (valid + block address).
- icache_req_accepted  out  1  icache request taken by memory this cycle.
- dcache_req_valid  in  1  dcache request present.
- dcache_req_cmd  in  MEM_COMMAND  MEM_LOAD or MEM_STORE.
- dcache_req_addr  in  ADDR  block-aligned address.
- dcache_req_data  in  MEM_BLOCK  store data.
- dcache_req_accepted  out  1  dcache request taken by memory this cycle.
- mem_command  out  MEM_COMMAND  MEM_NONE, MEM_LOAD or MEM_STORE to memory.
- mem_addr  out  ADDR  granted address.
- mem_wdata  out  MEM_BLOCK  store data; zero unless a store is granted.
- mem_req_tag  in  MEM_TAG  memory's same-cycle tag for the current command; 0 means rejected.
- mem_data_tag  in  MEM_TAG  tag of the returning data; 0 means none.
- icache_current_tag / dcache_current_tag  out  MEM_TAG  mem_req_tag forwarded to the winner; 0 to the loser.
- icache_data_tag / dcache_data_tag  out  MEM_TAG  mem_data_tag routed to the owner; 0 to the other requester.

## Operation
- Grant selection is combinational:
  - Dcache wins if dcache_req_valid and starve_cnt < STARVE_LIMIT.
  - Otherwise icache wins if icache_req.valid.
  - Otherwise dcache wins if dcache_req_valid.
  - Otherwise nobody wins and mem_command = MEM_NONE.
- Icache grant drives MEM_LOAD with mem_addr = icache_req.addr.
- Acceptance: accepted = (mem_command != MEM_NONE) & (mem_req_tag != 0). Only the winner's *_req_accepted can be 1.
- starve_cnt (saturating, width $clog2(STARVE_LIMIT+1)):
  - Increments when icache_req.valid and icache is not accepted.
  - Clears when icache is accepted or icache_req.valid = 0.
  - A memory rejection of an icache grant still increments it.
- Owner table: NUM_TAGS+1 entries {valid, owner}; index 0 is never written.
  - Set: on an accepted load, entry[mem_req_tag] <= {1, winner}.
  - Stores are never entered in the table.
  - Clear: when mem_data_tag != 0, entry[mem_data_tag].valid <= 0.
  - Same cycle, same tag for set and clear: set wins, because the new transaction reuses the tag.
- Response routing reads the registered table.
  - A valid entry sends mem_data_tag to that owner's *_data_tag; the other gets 0.
  - An invalid entry (unknown tag, or a store tag) gives both outputs 0.

## Timing
- Grant, accept and current-tag forwarding are zero-latency combinational in the request cycle.
- The owner-table update is visible one cycle after acceptance. The earliest legal data return for a tag is the cycle after its acceptance.
- Data-tag routing is zero-latency from mem_data_tag.
- Reset values: mem_command = MEM_NONE, mem_addr = 0, mem_wdata = 0; all accepted and tag outputs 0; starve_cnt = 0; all table entries invalid.
- Reset mid-operation clears the table. Data returning after reset for a pre-reset tag is dropped, with both *_data_tag = 0.
- Requesters hold their request until accepted. The arbiter keeps no request state.

## Structure
- Shared package (sys_defs.svh), existing: ADDR, MEM_BLOCK, MEM_TAG, MEM_COMMAND, I_ADDR_PACKET.
- Shared package, new:
  - MEM_OWNER enum {OWNER_ICACHE, OWNER_DCACHE}.
  - MEM_OWNER_ENTRY struct {valid, MEM_OWNER owner}.
- One sub-module: mem_owner_table.
  - Inputs: set_en, set_tag, set_owner, clr_tag.
  - Outputs: lookup of the clr_tag entry.
  - Enforces the set-over-clear priority.
- The arbiter top holds grant logic and starve_cnt.

## Test plan
- Reset, then idle → mem_command = MEM_NONE, all tags 0, table empty.
- Icache load 0x100 alone, mem_req_tag = 3 → icache_req_accepted = 1, icache_current_tag = 3. Later mem_data_tag = 3 → icache_data_tag = 3, dcache_data_tag = 0, entry 3 cleared.
- Both requesting for 6 cycles with STARVE_LIMIT = 4 and memory always accepting:
  - Dcache wins cycles 0-3.
  - Icache wins cycle 4, and starve_cnt returns to 0.
  - Dcache wins cycle 5.
- Dcache store 0x200, mem_req_tag = 5 → dcache_req_accepted = 1, mem_wdata = store data, no table entry. mem_data_tag = 5 → both *_data_tag = 0.
- Memory rejects (mem_req_tag = 0) for 2 cycles with only icache requesting → accepted = 0, starve_cnt = 2, no table write.
- Tag 7 returning (icache-owned) while a new dcache load is accepted with tag 7 → that cycle icache_data_tag = 7. Next cycle entry 7 is valid with owner = DCACHE.
- Reset asserted with tags 2 and 4 outstanding, then mem_data_tag = 2 → both *_data_tag = 0.
